// File: rtl/fifo_pkg.sv
// Shared types and defaults for the FIFO blocks and their write-side arbiter.
// Holds the write-arbiter FSM state type, default data width and requester count.
package fifo_pkg;

    localparam int FIFO_DW   = 8;
    localparam int FIFO_NREQ = 4;

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } wr_state_t;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wr_port_arbiter_rr_pick.sv
// Combinational round-robin picker: search starts at last+1 modulo NREQ.
// Ports: req (request bits), last (previous winner), winner (one-hot), valid.
module rr_pick
    import fifo_pkg::*;
#(
    parameter int NREQ = FIFO_NREQ,
    parameter int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] winner,
    output logic            valid
);

    always_comb begin
        logic [IW-1:0] idx;
        idx    = '0;
        winner = '0;
        valid  = 1'b0;
        // k = NREQ wraps back to last itself, so it is checked last.
        for (int k = 1; k <= NREQ; k++) begin
            idx = IW'((int'(last) + k) % NREQ);
            if (!valid && req[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wr_port_arbiter.sv
// Write-port arbiter: grants one requester at a time a whole burst into the FIFO.
// Ports: w_clk, w_rst (async high), req/len/wdata (per requester), full (FIFO),
//        gnt (registered one-hot), ack, fifo_w_en, fifo_data, busy, abort.
module wr_port_arbiter
    import fifo_pkg::*;
#(
    parameter int NREQ = FIFO_NREQ,
    parameter int DW   = FIFO_DW,
    parameter int LW   = 3
) (
    input  logic               w_clk,
    input  logic               w_rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*LW-1:0] len,
    input  logic [NREQ*DW-1:0] wdata,
    input  logic               full,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic               fifo_w_en,
    output logic [DW-1:0]      fifo_data,
    output logic               busy,
    output logic               abort
);

    localparam int            IW       = idx_w(NREQ);
    localparam logic [IW-1:0] LAST_RST = IW'(NREQ - 1);

    wr_state_t       state, state_n;
    logic [NREQ-1:0] gnt_n;
    logic [IW-1:0]   cur, cur_n;
    logic [IW-1:0]   last, last_n;
    logic [LW-1:0]   beat_cnt, beat_n;

    logic [NREQ-1:0] pick_oh;
    logic            pick_vld;
    logic [IW-1:0]   pick_idx;

    logic [LW-1:0]   len_a  [NREQ];
    logic [DW-1:0]   data_a [NREQ];
    logic            in_xfer;
    logic            req_cur;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            len_a[i]  = len[i*LW +: LW];
            data_a[i] = wdata[i*DW +: DW];
        end
    end

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .last   (last),
        .winner (pick_oh),
        .valid  (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_oh[i]) begin
                pick_idx = IW'(i);
            end
        end
    end

    assign in_xfer   = (state == XFER);
    assign req_cur   = req[cur];
    assign fifo_w_en = in_xfer & ~full & req_cur;
    assign ack       = gnt & {NREQ{fifo_w_en}};
    assign fifo_data = in_xfer ? data_a[cur] : '0;
    assign busy      = in_xfer;
    // A dropped request wins over full: the burst ends even if the FIFO is full.
    assign abort     = in_xfer & ~req_cur;

    always_ff @(posedge w_clk or posedge w_rst) begin
        if (w_rst) begin
            state    <= IDLE;
            gnt      <= '0;
            cur      <= '0;
            last     <= LAST_RST;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            cur      <= cur_n;
            last     <= last_n;
            beat_cnt <= beat_n;
        end
    end

    always_comb begin
        state_n = state;
        gnt_n   = gnt;
        cur_n   = cur;
        last_n  = last;
        beat_n  = beat_cnt;
        unique case (state)
            IDLE: begin
                if (pick_vld) begin
                    state_n = XFER;
                    gnt_n   = pick_oh;
                    cur_n   = pick_idx;
                    beat_n  = len_a[pick_idx];
                end
            end
            XFER: begin
                if (!req_cur) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    last_n  = cur;
                end else if (!full) begin
                    if (beat_cnt == '0) begin
                        state_n = IDLE;
                        gnt_n   = '0;
                        last_n  = cur;
                    end else begin
                        beat_n = beat_cnt - 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_wr_port_arbiter.sv
// Self-checking bench for wr_port_arbiter: burst vector table, scoreboard on
// FIFO writes, and hand sequences for round-robin, last-update and reset.
module tb_wr_port_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int LW   = 3;

    logic               w_clk = 1'b0;
    logic               w_rst;
    logic [NREQ-1:0]    req;
    logic [NREQ*LW-1:0] len;
    logic [NREQ*DW-1:0] wdata;
    logic               full;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic               fifo_w_en;
    logic [DW-1:0]      fifo_data;
    logic               busy;
    logic               abort;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] sb [$];

    typedef struct {
        int who;
        int blen;
        int stall;
        int drop;
        int exp_beats;
        int exp_abort;
    } vec_t;

    vec_t vecs [6];

    wr_port_arbiter #(
        .NREQ (NREQ),
        .DW   (DW),
        .LW   (LW)
    ) dut (
        .w_clk     (w_clk),
        .w_rst     (w_rst),
        .req       (req),
        .len       (len),
        .wdata     (wdata),
        .full      (full),
        .gnt       (gnt),
        .ack       (ack),
        .fifo_w_en (fifo_w_en),
        .fifo_data (fifo_data),
        .busy      (busy),
        .abort     (abort)
    );

    always #5 w_clk = ~w_clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_len(input int i, input int v);
        len[i*LW +: LW] = LW'(v);
    endtask

    task automatic set_data(input int i, input logic [DW-1:0] v);
        wdata[i*DW +: DW] = v;
    endtask

    always @(negedge w_clk) begin
        if (!w_rst) begin
            if (fifo_w_en) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_underflow: got write %0h want none",
                             fifo_data);
                end else begin
                    chk("fifo_data", {24'h0, fifo_data}, {24'h0, sb.pop_front()});
                end
                chk("ack_eq_gnt", {28'h0, ack}, {28'h0, gnt});
            end else begin
                chk("ack_idle", {28'h0, ack}, 32'h0);
            end
        end
    end

    task automatic run_burst(input vec_t v, input int vi);
        logic [DW-1:0] base;
        int  beats, aborts, xc, lat, c, sc;
        bit  granted, done, got_ack;
        base = DW'(8'h40 + vi * 16);
        beats = 0; aborts = 0; xc = 0; lat = -1; c = 0; sc = 0;
        granted = 1'b0; done = 1'b0;
        for (int k = 0; k < v.exp_beats; k++) begin
            sb.push_back(DW'(base + k));
        end
        req = NREQ'(1 << v.who);
        set_len(v.who, v.blen);
        set_data(v.who, base);
        full = 1'b0;
        while (!done && c < 60) begin
            @(negedge w_clk);
            if (abort) aborts++;
            if (fifo_w_en) beats++;
            if (gnt != '0) begin
                if (!granted) begin
                    granted = 1'b1;
                    lat = c;
                end
                xc++;
                chk("gnt_held", {28'h0, gnt}, 32'(1 << v.who));
                chk("busy_xfer", {31'h0, busy}, 32'h1);
            end else if (granted) begin
                done = 1'b1;
            end
            got_ack = ack[v.who];
            @(posedge w_clk);
            #1;
            c++;
            if (got_ack) set_data(v.who, DW'(base + beats));
            if (gnt[v.who]) sc++;
            full = gnt[v.who] && (sc <= v.stall);
            if (got_ack && beats == v.blen + 1) req = '0;
            if (v.drop >= 0 && beats == v.drop) req = '0;
        end
        req  = '0;
        full = 1'b0;
        chk($sformatf("v%0d_done", vi), {31'h0, done}, 32'h1);
        chk($sformatf("v%0d_latency", vi), lat, 1);
        chk($sformatf("v%0d_beats", vi), beats, v.exp_beats);
        chk($sformatf("v%0d_aborts", vi), aborts, v.exp_abort);
        chk($sformatf("v%0d_xfer_cycles", vi), xc,
            v.exp_beats + v.stall + v.exp_abort);
        chk($sformatf("v%0d_busy_end", vi), {31'h0, busy}, 32'h0);
    endtask

    initial begin
        int order [5];
        vecs[0] = '{who: 0, blen: 3, stall: 0, drop: -1, exp_beats: 4, exp_abort: 0};
        vecs[1] = '{who: 2, blen: 1, stall: 3, drop: -1, exp_beats: 2, exp_abort: 0};
        vecs[2] = '{who: 3, blen: 0, stall: 0, drop: -1, exp_beats: 1, exp_abort: 0};
        vecs[3] = '{who: 1, blen: 7, stall: 0, drop: -1, exp_beats: 8, exp_abort: 0};
        vecs[4] = '{who: 2, blen: 2, stall: 2, drop: -1, exp_beats: 3, exp_abort: 0};
        vecs[5] = '{who: 1, blen: 7, stall: 0, drop: 2,  exp_beats: 2, exp_abort: 1};
        order = '{0, 1, 2, 3, 0};

        w_rst = 1'b1;
        req   = '0;
        len   = '0;
        wdata = '0;
        full  = 1'b0;
        repeat (3) @(posedge w_clk);
        #1;
        chk("rst_gnt", {28'h0, gnt}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_abort", {31'h0, abort}, 32'h0);
        chk("rst_wen", {31'h0, fifo_w_en}, 32'h0);
        chk("rst_ack", {28'h0, ack}, 32'h0);
        chk("rst_data", {24'h0, fifo_data}, 32'h0);
        w_rst = 1'b0;
        @(posedge w_clk);
        #1;
        chk("idle_gnt", {28'h0, gnt}, 32'h0);

        req = 4'b1111;
        for (int i = 0; i < NREQ; i++) begin
            set_len(i, 0);
            set_data(i, DW'(8'hA0 + i));
        end
        for (int k = 0; k < 5; k++) sb.push_back(DW'(8'hA0 + order[k]));
        for (int c = 0; c < 10; c++) begin
            @(negedge w_clk);
            if (c % 2 == 1)
                chk($sformatf("rr_c%0d", c), {28'h0, gnt},
                    32'(1 << order[(c - 1) / 2]));
            else
                chk($sformatf("rr_c%0d", c), {28'h0, gnt}, 32'h0);
            @(posedge w_clk);
            #1;
            if (c == 8) req = 4'b0001;
            if (c == 9) req = '0;
        end

        for (int i = 0; i < 6; i++) begin
            run_burst(vecs[i], i);
            repeat (2) @(posedge w_clk);
            #1;
        end

        len = '0;
        set_data(2, 8'hC2);
        sb.push_back(8'hC2);
        req = 4'b1111;
        @(negedge w_clk);
        chk("last_idle", {28'h0, gnt}, 32'h0);
        @(posedge w_clk);
        #1;
        req = 4'b0100;
        @(negedge w_clk);
        chk("last_after_abort", {28'h0, gnt}, 32'h4);
        @(posedge w_clk);
        #1;
        req = '0;
        @(negedge w_clk);
        chk("last_end", {28'h0, gnt}, 32'h0);
        @(posedge w_clk);
        #1;

        req = 4'b0001;
        set_len(0, 3);
        set_data(0, 8'hD0);
        sb.push_back(8'hD0);
        @(posedge w_clk);
        #1;
        chk("mid_gnt", {28'h0, gnt}, 32'h1);
        @(posedge w_clk);
        #1;
        set_data(0, 8'hD1);
        chk("mid_beat2_wen", {31'h0, fifo_w_en}, 32'h1);
        w_rst = 1'b1;
        #1;
        chk("mid_rst_gnt", {28'h0, gnt}, 32'h0);
        chk("mid_rst_wen", {31'h0, fifo_w_en}, 32'h0);
        chk("mid_rst_ack", {28'h0, ack}, 32'h0);
        chk("mid_rst_abort", {31'h0, abort}, 32'h0);
        chk("mid_rst_busy", {31'h0, busy}, 32'h0);
        req = 4'b1010;
        len = '0;
        set_data(1, 8'hE1);
        sb.push_back(8'hE1);
        @(posedge w_clk);
        #1;
        w_rst = 1'b0;
        @(negedge w_clk);
        chk("post_rst_idle", {28'h0, gnt}, 32'h0);
        @(posedge w_clk);
        #1;
        chk("post_rst_first", {28'h0, gnt}, 32'h2);
        req = 4'b0010;
        @(posedge w_clk);
        #1;
        req = '0;
        @(negedge w_clk);
        chk("post_rst_end", {28'h0, gnt}, 32'h0);
        repeat (2) @(posedge w_clk);
        #1;

        chk("sb_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
